// File: rtl/pg_gen_stage.sv
// ============================================================================
// Module      : pg_gen_stage
// Description : Registered propagate/generate front end for the add/sub
//               datapath. A 2-entry skid buffer sits between the source and the carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pg_gen_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g,
    output logic             c_in,
    output logic             op_sub
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_two   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main_p, r_main_g, r_skid_p, r_skid_g;
    logic             r_main_sub, r_skid_sub;

    logic [WIDTH-1:0] w_b_eff, w_p, w_g;
    logic             w_in_acc, w_out_acc;
    logic             w_ld_main_in, w_ld_main_skid, w_ld_skid;

    // Subtraction is A + ~B + 1; the +1 travels as carry-in (== sub).
    assign w_b_eff = b ^ {WIDTH{sub}};
    assign w_p     = a ^ w_b_eff;
    assign w_g     = a & w_b_eff;

    assign out_valid = (r_state != c_st_empty);
    assign in_ready  = ~rst & (r_state != c_st_two);
    assign w_in_acc  = in_valid & in_ready;
    assign w_out_acc = out_valid & out_ready;

    assign p      = r_main_p;
    assign g      = r_main_g;
    assign c_in   = r_main_sub;
    assign op_sub = r_main_sub;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            c_st_empty: begin
                if (w_in_acc) begin
                    w_ld_main_in = 1'b1;
                    w_state_nxt  = c_st_one;
                end
            end
            c_st_one: begin
                if (w_in_acc && w_out_acc) begin
                    w_ld_main_in = 1'b1;
                end else if (w_out_acc) begin
                    w_state_nxt = c_st_empty;
                end else if (w_in_acc) begin
                    w_ld_skid   = 1'b1;
                    w_state_nxt = c_st_two;
                end
            end
            c_st_two: begin
                if (w_out_acc) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nxt    = c_st_one;
                end
            end
            default: w_state_nxt = c_st_empty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_empty;
            r_main_p   <= '0;
            r_main_g   <= '0;
            r_main_sub <= 1'b0;
            r_skid_p   <= '0;
            r_skid_g   <= '0;
            r_skid_sub <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_main_in) begin
                r_main_p   <= w_p;
                r_main_g   <= w_g;
                r_main_sub <= sub;
            end else if (w_ld_main_skid) begin
                r_main_p   <= r_skid_p;
                r_main_g   <= r_skid_g;
                r_main_sub <= r_skid_sub;
            end
            if (w_ld_skid) begin
                r_skid_p   <= w_p;
                r_skid_g   <= w_g;
                r_skid_sub <= sub;
            end
        end
    end

endmodule

`default_nettype wire
